// File: rtl/spectrum_smoother.sv
// Per-bin attack/decay smoothing of FFT magnitudes ahead of the display RAM.
// State lives in one simple dual-port RAM; a clear sweep zeroes it after reset or on request.
module spectrum_smoother #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 9,
    parameter int unsigned ATTACK_SHIFT = 1,
    parameter int unsigned DECAY_SHIFT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 bypass,
    input  logic                 clear,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e               state_q;
    logic [ADDR_BITS-1:0] sweep_q;
    logic                 busy_q;

    logic                 pipe_valid_q;
    logic                 pipe_bypass_q;
    logic [ADDR_BITS-1:0] pipe_addr_q;
    logic [DATA_BITS-1:0] pipe_data_q;

    logic [DATA_BITS-1:0] rd_data_q;
    logic                 fwd_hit_q;
    logic [DATA_BITS-1:0] fwd_data_q;

    logic [ADDR_BITS-1:0] out_addr_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 frame_done_q;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 accept;
    logic                 wr_en;
    logic [DATA_BITS-1:0] old_val;
    logic [DATA_BITS:0]   old_ext;
    logic [DATA_BITS:0]   in_ext;
    logic [DATA_BITS:0]   rise_step;
    logic [DATA_BITS:0]   fall_step;
    logic [DATA_BITS:0]   new_ext;
    logic [DATA_BITS-1:0] new_val;

    // Strobes coinciding with clear are dropped; in-flight writes are suppressed during the sweep.
    assign accept  = in_valid && (state_q == StRun) && !clear;
    assign wr_en   = pipe_valid_q && (state_q == StRun);
    assign old_val = fwd_hit_q ? fwd_data_q : rd_data_q;

    assign old_ext   = {1'b0, old_val};
    assign in_ext    = {1'b0, pipe_data_q};
    assign rise_step = (in_ext - old_ext) >> ATTACK_SHIFT;
    assign fall_step = (old_ext - in_ext) >> DECAY_SHIFT;

    always_comb begin
        new_ext = old_ext;
        if (pipe_bypass_q) begin
            new_ext = in_ext;
        end else if (in_ext > old_ext) begin
            new_ext = old_ext + rise_step;
        end else if (in_ext < old_ext) begin
            new_ext = old_ext - ((fall_step == '0) ? {{DATA_BITS{1'b0}}, 1'b1} : fall_step);
        end
        new_val = new_ext[DATA_BITS] ? '1 : new_ext[DATA_BITS-1:0];
    end

    // Block RAM: read-before-write on the synchronous read port.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[sweep_q] <= '0;
        end else if (wr_en) begin
            mem[pipe_addr_q] <= new_val;
        end
        rd_data_q <= mem[in_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StClear;
            sweep_q       <= '0;
            busy_q        <= 1'b1;
            pipe_valid_q  <= 1'b0;
            pipe_bypass_q <= 1'b0;
            pipe_addr_q   <= '0;
            pipe_data_q   <= '0;
            fwd_hit_q     <= 1'b0;
            fwd_data_q    <= '0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (&sweep_q) begin
                        state_q <= StRun;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (clear) begin
                        state_q <= StClear;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: state_q <= StClear;
            endcase

            pipe_valid_q <= accept;
            if (accept) begin
                pipe_addr_q   <= in_addr;
                pipe_data_q   <= in_data;
                pipe_bypass_q <= bypass;
            end

            // RAM read misses the write landing on the same edge; take the result directly.
            fwd_hit_q  <= accept && wr_en && (in_addr == pipe_addr_q);
            fwd_data_q <= new_val;

            out_valid_q  <= pipe_valid_q;
            frame_done_q <= pipe_valid_q && (&pipe_addr_q);
            if (pipe_valid_q) begin
                out_addr_q <= pipe_addr_q;
                out_data_q <= new_val;
            end
        end
    end

    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: doc/spectrum_smoother.md
Name: spectrum_smoother

Overview:
- Per-bin temporal smoothing stage between the 256-point FFT magnitude stream and the display RAM write port.
- Each incoming magnitude is combined with that bin's previous smoothed value:
  - fast attack when the magnitude rises;
  - slow decay when it falls.
- Removes frame-to-frame flicker in the HDMI spectrum graph.
- Output stream has the same addr/data/valid form as the input, so it drops in front of the display RAM unchanged.

Parameters:
- ADDR_BITS, 8: bin address width; the state memory holds 2^ADDR_BITS entries.
- DATA_BITS, 9: magnitude width, unsigned.
- ATTACK_SHIFT, 1: rise step is (new-old)>>ATTACK_SHIFT; 0 means instant attack.
- DECAY_SHIFT, 3: fall step is (old-new)>>DECAY_SHIFT, with a minimum of 1.

Ports:
- clk  in  1  system clock (25 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- in_addr  in  ADDR_BITS  bin index of the incoming magnitude.
- in_data  in  DATA_BITS  incoming magnitude.
- in_valid  in  1  one-cycle strobe per bin.
- bypass  in  1  when 1, out_data = in_data; state memory is still written with in_data.
- clear  in  1  one-cycle request to zero all state.
- out_addr  out  ADDR_BITS  bin index of the smoothed value.
- out_data  out  DATA_BITS  smoothed magnitude.
- out_valid  out  1  one-cycle strobe.
- frame_done  out  1  one-cycle pulse coincident with out_valid for the all-ones address.
- busy  out  1  high while the clear sweep runs.

Behaviour:
Reset values:
- out_addr=0, out_data=0, out_valid=0, frame_done=0, busy=1.
- FSM enters CLEAR with sweep counter=0.

FSM states:
- CLEAR:
  - Writes 0 to state memory at the sweep counter address, one address per cycle.
  - After writing address 2^ADDR_BITS-1: go to RUN; busy falls on the next cycle.
  - Sweep takes exactly 2^ADDR_BITS cycles.
  - in_valid is ignored; no out_valid is produced.
- RUN:
  - Processes in_valid strobes.
  - clear=1 goes to CLEAR with counter=0 and busy=1 on the next cycle.
  - An in_valid arriving in the same cycle as clear is dropped.
  - Any transaction already in the pipeline completes its out_valid, but its memory write is superseded by the sweep.

Pipeline (RUN):
- Stage 0: in_valid issues a synchronous read of the state memory at in_addr; addr/data are registered.
- Stage 1: compute new = f(old, in) and write it back to memory at addr.
  - out_valid, out_addr and out_data are registered here.
  - Fixed latency: out_valid asserts exactly 2 cycles after in_valid.
- Throughput: one strobe per cycle is sustained.
- Read-after-write hazard: if stage 0's address equals the address being written in stage 1 in the same cycle, old is forwarded from the stage-1 result, not from memory.
  - Required for back-to-back same-address strobes.

Arithmetic f(old, in), all unsigned, DATA_BITS wide:
- in > old: new = old + ((in-old)>>ATTACK_SHIFT). Never exceeds in.
- in < old: d = (old-in)>>DECAY_SHIFT; new = old - max(d,1). Never goes below in.
- in = old: new = old.
- No intermediate overflow: differences are computed in DATA_BITS+1 bits.
- bypass=1: new = in. Output and memory both take in.

Other rules:
- frame_done is asserted with out_valid when out_addr = all ones; otherwise 0.
- Addresses need not arrive in order; any order and any gaps are accepted.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); a full CLEAR sweep follows.
- Memory maps to one block RAM: 1 synchronous read port, 1 write port.

Test Plan:
1. Reset release -> busy=1 for exactly 256 cycles then 0; in_valid strobes during busy produce no out_valid.
2. ATTACK_SHIFT=1, DECAY_SHIFT=3: bin 5 fed 200 over 3 frames -> out_data 100, 150, 175. Each out_valid arrives exactly 2 cycles after its in_valid.
3. Decay, bin 7 state 100, feed 0 repeatedly -> 88, 77, 68. State 3 fed 0 -> 2, 1, 0 (minimum step of 1), then holds 0.
4. Back-to-back in_valid on addr 9 with data 200 then 200, from state 0 -> outputs 100 then 150 (forwarding exercised). Interleave with addr 10 to confirm no cross-talk.
5. Full frame of 256 sequential strobes -> frame_done pulses once, with out_addr=255. bypass=1 frame -> out_data equals in_data exactly. Next non-bypass frame smooths from those values.
6. clear pulse mid-frame at addr 128 -> busy high for 256 cycles. The next frame of 200s yields 100 on every bin, including bins 0-127.
